// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, output-registered ALU.
// Alternates grants on ties and returns each result to its owner as a one-cycle pulse.
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   input  logic [2:0]       req0_mode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,

   input  logic             req1_valid,
   input  logic [2:0]       req1_mode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,

   output logic             resp0_valid,
   output logic             resp1_valid,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             resp_carry,

   output logic             busy,

   output logic             alu_enable,
   output logic [2:0]       alu_mode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   input  logic             alu_carry
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             last_grant;
   logic             owner;
   logic [2:0]       op_mode;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic             grant_valid;
   logic             grant_id;

   // Grant is only offered while IDLE; on a tie the requester not served last wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
         end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end
   end

   assign req0_ready = grant_valid && !grant_id;
   assign req1_ready = grant_valid &&  grant_id;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = ISSUE;
         ISSUE:   state_next = COLLECT;
         COLLECT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      alu_enable = (state == ISSUE);
   end

   // Operand capture: the in-flight operation is isolated from later request activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_mode    <= '0;
         op_a       <= '0;
         op_b       <= '0;
      end else if (grant_valid) begin
         last_grant <= grant_id;
         owner      <= grant_id;
         op_mode    <= grant_id ? req1_mode : req0_mode;
         op_a       <= grant_id ? req1_a    : req0_a;
         op_b       <= grant_id ? req1_b    : req0_b;
      end
   end

   // The ALU is driven straight from the capture registers, so it stays quiet while idle.
   assign alu_mode = op_mode;
   assign alu_a    = op_a;
   assign alu_b    = op_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp_data   <= '0;
         resp_zero   <= 1'b0;
         resp_carry  <= 1'b0;
      end else begin
         resp0_valid <= (state == COLLECT) && !owner;
         resp1_valid <= (state == COLLECT) &&  owner;
         if (state == COLLECT) begin
            resp_data  <= alu_out;
            resp_zero  <= alu_zero;
            resp_carry <= alu_carry;
         end
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      !(req0_ready && req1_ready));

   a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
      (req0_ready || req1_ready) |-> !busy);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a stub output-registered ALU
// and a transaction-level reference model (cycle counts and an expected-response queue).
module tb_alu_arbiter;
   localparam int W = 8;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic [2:0]   req0_mode, req1_mode;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         resp0_valid, resp1_valid;
   logic [W-1:0] resp_data;
   logic         resp_zero, resp_carry;
   logic         busy;
   logic         alu_enable;
   logic [2:0]   alu_mode;
   logic [W-1:0] alu_a, alu_b;
   logic [W-1:0] alu_out;
   logic         alu_zero, alu_carry;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp_data(resp_data), .resp_zero(resp_zero), .resp_carry(resp_carry),
      .busy(busy),
      .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] data;
      logic         z;
      logic         c;
   } alu_res_t;

   typedef struct {
      int       due;
      logic     owner;
      alu_res_t res;
   } resp_t;

   function automatic alu_res_t alu_ref(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
      alu_res_t r;
      logic [W:0] s;
      s   = '0;
      r.c = 1'b0;
      case (m)
         OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r.data = s[W-1:0]; r.c = s[W]; end
         OP_SUB:  begin r.data = a - b; r.c = (a < b); end
         OP_AND:  r.data = a & b;
         OP_OR:   r.data = a | b;
         default: r.data = a ^ b;
      endcase
      r.z = (r.data == '0);
      return r;
   endfunction

   // Stub ALU: registers its result on edges where alu_enable is high.
   initial begin
      alu_out   = '0;
      alu_zero  = 1'b0;
      alu_carry = 1'b0;
   end
   always @(posedge clk)
      if (alu_enable) {alu_out, alu_zero, alu_carry} <= alu_ref(alu_mode, alu_a, alu_b);

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int           since;
   int           cyc;
   logic         last_g;
   logic [2:0]   l_mode;
   logic [W-1:0] l_a, l_b;
   alu_res_t     held;
   resp_t        exp_q[$];

   // Observations used by the directed fairness scenarios
   int           obs_acc;
   logic [7:0]   obs_ids;
   int           en_pairs;
   logic         prev_en;

   task automatic model_reset();
      since  = 100;
      last_g = 1'b1;
      l_mode = '0;
      l_a    = '0;
      l_b    = '0;
      held   = '0;
      exp_q.delete();
      prev_en = 1'b0;
   endtask

   task automatic set_idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_mode  = '0;   req1_mode  = '0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
   endtask

   task automatic reset_dut();
      set_idle_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_alu_en", alu_enable, 0);
      check("rst_alu_mode", alu_mode, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_flags", {resp_zero, resp_carry}, 0);
      check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drive_cycle(input logic v0, input logic [2:0] m0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic v1, input logic [2:0] m1, input logic [W-1:0] a1, input logic [W-1:0] b1);
      logic  g_v, g_id, e_rv0, e_rv1;
      resp_t h;
      @(negedge clk);
      req0_valid = v0; req0_mode = m0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_mode = m1; req1_a = a1; req1_b = b1;
      #1;
      g_v  = (since >= 3) && (v0 || v1);
      g_id = (v0 && v1) ? ~last_g : v1;
      check("req0_ready", req0_ready, g_v && !g_id);
      check("req1_ready", req1_ready, g_v && g_id);
      check("busy", busy, (since == 1) || (since == 2));
      check("alu_enable", alu_enable, since == 1);
      check("alu_mode", alu_mode, l_mode);
      check("alu_a", alu_a, l_a);
      check("alu_b", alu_b, l_b);
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         h     = exp_q.pop_front();
         held  = h.res;
         e_rv0 = !h.owner;
         e_rv1 = h.owner;
      end
      check("resp0_valid", resp0_valid, e_rv0);
      check("resp1_valid", resp1_valid, e_rv1);
      check("resp_data", resp_data, held.data);
      check("resp_zero", resp_zero, held.z);
      check("resp_carry", resp_carry, held.c);

      if (req0_ready || req1_ready) begin
         obs_acc++;
         obs_ids = {obs_ids[6:0], req1_ready};
      end
      if (alu_enable && prev_en) en_pairs++;
      prev_en = alu_enable;

      if (g_v) begin
         last_g = g_id;
         l_mode = g_id ? m1 : m0;
         l_a    = g_id ? a1 : a0;
         l_b    = g_id ? b1 : b0;
         exp_q.push_back('{cyc + 3, g_id, alu_ref(l_mode, l_a, l_b)});
         since  = 1;
      end else if (since < 100) begin
         since++;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, '0, 0, '0, '0, '0);
   endtask

   // Asynchronous reset pulse landing mid-cycle, while the model is in its issue cycle.
   task automatic pulse_reset();
      @(negedge clk);
      set_idle_inputs();
      #1;
      check("prerst_alu_en", alu_enable, since == 1);
      cyc++;
      rst_n = 1'b0;
      #1;
      check("midrst_alu_en", alu_enable, 0);
      check("midrst_busy", busy, 0);
      check("midrst_resp_valid", {resp0_valid, resp1_valid}, 0);
      check("midrst_alu_a", alu_a, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      cyc     = 0;
      obs_acc = 0;
      obs_ids = '0;
      en_pairs = 0;
      model_reset();
      reset_dut();

      // Single requester 0: ADD 0x0F + 0x01
      drive_cycle(1, OP_ADD, 8'h0F, 8'h01, 0, '0, '0, '0);
      idle(1);
      check("s31_alu_en", alu_enable, 1);
      idle(2);
      check("s31_resp0_valid", resp0_valid, 1);
      check("s31_resp1_valid", resp1_valid, 0);
      check("s31_data", resp_data, 8'h10);
      check("s31_flags", {resp_zero, resp_carry}, 2'b00);

      // Single requester 1: SUB 0x01 - 0x01
      drive_cycle(0, '0, '0, '0, 1, OP_SUB, 8'h01, 8'h01);
      idle(3);
      check("s32_resp1_valid", resp1_valid, 1);
      check("s32_data", resp_data, 8'h00);
      check("s32_zero", resp_zero, 1);

      // Tie after reset: requester 0 first, then 1, then 0 again
      reset_dut();
      obs_acc = 0;
      obs_ids = '0;
      for (int i = 0; i < 9; i++) begin
         drive_cycle(1, OP_AND, 8'hF0, 8'h0F, 1, OP_OR, 8'hF0, 8'h0F);
         if (i == 3) begin
            check("s33_first_owner", {resp0_valid, resp1_valid}, 2'b10);
            check("s33_first_data", resp_data, 8'h00);
            check("s33_first_zero", resp_zero, 1);
         end
         if (i == 6) begin
            check("s33_second_owner", {resp0_valid, resp1_valid}, 2'b01);
            check("s33_second_data", resp_data, 8'hFF);
         end
      end
      check("s33_accepts", obs_acc, 3);
      check("s33_order", obs_ids[2:0], 3'b010);
      idle(3);

      // ADD with carry-out; operands scrambled during ISSUE must not matter
      drive_cycle(1, OP_ADD, 8'hFF, 8'h01, 0, '0, '0, '0);
      drive_cycle(0, OP_SUB, 8'h12, 8'h34, 0, '0, '0, '0);
      idle(2);
      check("s34_resp0_valid", resp0_valid, 1);
      check("s34_data", resp_data, 8'h00);
      check("s34_flags", {resp_zero, resp_carry}, 2'b11);

      // Reset during ISSUE aborts the op; the next request completes
      drive_cycle(1, OP_ADD, 8'h10, 8'h20, 0, '0, '0, '0);
      pulse_reset();
      idle(4);
      drive_cycle(1, OP_OR, 8'h30, 8'h03, 0, '0, '0, '0);
      idle(3);
      check("s35_resp0_valid", resp0_valid, 1);
      check("s35_data", resp_data, 8'h33);

      // Twelve cycles of continuous contention
      reset_dut();
      obs_acc  = 0;
      obs_ids  = '0;
      en_pairs = 0;
      for (int i = 0; i < 12; i++)
         drive_cycle(1, 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                     1, 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      check("s36_accepts", obs_acc, 4);
      check("s36_order", obs_ids[3:0], 4'b0101);
      check("s36_enable_gap", en_pairs, 0);
      idle(3);

      // Randomized traffic, including requests that vanish before being served
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1'($urandom_range(0, 9) < 6), 3'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 9) < 6), 3'($urandom), 8'($urandom), 8'($urandom));
         if (i == 200) pulse_reset();
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width; all data ports below are WIDTH bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-006 req0_mode / req1_mode  input  3  ALU opcode (OP_ADD, OP_SUB, OP_AND, OP_OR encodings).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-009 resp0_valid / resp1_valid  output  1  one-cycle pulse, result for requester k is on resp_*.
REQ-010 resp_data  output  WIDTH; resp_zero, resp_carry  output  1; shared response bus.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 alu_enable  output  1; alu_mode  output  3; alu_a, alu_b  output  WIDTH  drive the shared ALU.
REQ-013 alu_out  input  WIDTH; alu_zero, alu_carry  input  1  registered ALU results.

Function
REQ-014 The ALU SHALL be treated as registering out/flags on the clk edge where alu_enable=1; results are read on the following cycle.
REQ-015 FSM states SHALL be IDLE, ISSUE, COLLECT; transitions IDLE->ISSUE on acceptance, ISSUE->COLLECT unconditionally, COLLECT->IDLE unconditionally.
REQ-016 In IDLE, reqk_ready SHALL be combinationally high only for the granted requester k; both ready low outside IDLE; at most one ready high per cycle.
REQ-017 Grant: only one valid -> that requester; both valid -> requester not in last_grant; neither -> no grant, stay IDLE.
REQ-018 last_grant SHALL update to k on each acceptance (valid && ready).
REQ-019 On acceptance, mode, a, b and owner id SHALL be latched; later changes on req inputs SHALL NOT affect the in-flight operation.
REQ-020 In ISSUE, alu_enable=1 and alu_mode/alu_a/alu_b SHALL drive the latched values; alu_enable=0 in all other states.
REQ-021 alu_mode/alu_a/alu_b SHALL hold the latched values outside ISSUE (no toggling when idle).
REQ-022 In COLLECT, alu_out/alu_zero/alu_carry SHALL be registered into resp_data/resp_zero/resp_carry, and resp<owner>_valid SHALL pulse high for exactly the next cycle (first IDLE cycle).
REQ-023 resp_data/flags SHALL hold their value until the next response; only the owner's resp_valid pulses.
REQ-024 Latency: acceptance edge to resp_valid high = 3 cycles; max throughput one operation per 3 cycles.
REQ-025 A requester whose valid drops before acceptance SHALL be dropped with no side effect; valid held through acceptance is required of requesters.
REQ-026 Opcodes SHALL be passed through unmodified; width, carry and zero semantics are owned by the ALU.
REQ-027 A request may be accepted in the same IDLE cycle that a resp_valid pulse is driven.

Reset
REQ-028 rst_n low SHALL immediately force: state=IDLE, last_grant=1 (requester 0 wins first tie), alu_enable=0, alu_mode=0, alu_a=alu_b=0, resp_data=0, resp_zero=resp_carry=0, resp0_valid=resp1_valid=0, busy=0.
REQ-029 Reset asserted in ISSUE or COLLECT SHALL abort the operation; no resp_valid SHALL be produced for it after release.
REQ-030 After rst_n release, the first acceptance is possible in the first clock cycle.

Verification
REQ-031 Req0 only, OP_ADD 0x0F+0x01 -> req0_ready 1 cycle, alu_enable 1 cycle later, resp0_valid 3 cycles after acceptance, resp_data=0x10, zero=0, carry=0, resp1_valid stays 0.
REQ-032 Req1 only, OP_SUB 0x01-0x01 -> resp1_valid pulse, resp_data=0x00, resp_zero=1.
REQ-033 Both valid after reset, req0 OP_AND 0xF0,0x0F and req1 OP_OR 0xF0,0x0F held -> req0 served first (0x00, zero=1), then req1 (0xFF); third tie goes to req0 again.
REQ-034 Req0 OP_ADD 0xFF+0x01 -> resp_data=0x00, carry=1, zero=1; req0 operands changed during ISSUE -> result unchanged.
REQ-035 rst_n pulsed low during ISSUE -> alu_enable drops immediately, busy=0, no resp_valid for that op; next request completes normally.
REQ-036 Both valid continuously for 12 cycles -> exactly 4 acceptances, alternating 0,1,0,1, alu_enable never high two consecutive cycles.
